// File: rtl/one_to_five_demux.sv
// Registered 1-to-5 demux with valid/ready handshake, one holding
// register per lane, illegal-select drop reporting and saturating drop count.
module one_to_five_demux #(
  parameter int RV_BIT_NUM_FIVE = 32,
  parameter int MUX_WIDTH_FIVE  = 3,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [MUX_WIDTH_FIVE-1:0]    sel,
  input  logic [RV_BIT_NUM_FIVE-1:0]   d,
  output logic [4:0]                   out_valid,
  input  logic [4:0]                   out_ready,
  output logic [RV_BIT_NUM_FIVE*5-1:0] q,
  output logic                         err_sel,
  output logic [CNT_WIDTH-1:0]         drop_count
);

  localparam int LANES = 5;

  logic [LANES-1:0]           r_full;
  logic [RV_BIT_NUM_FIVE-1:0] r_data [LANES];
  logic                       r_err;
  logic [CNT_WIDTH-1:0]       r_cnt;

  logic [LANES-1:0] w_hit;
  logic [LANES-1:0] w_load;
  logic             w_legal;
  logic             w_ready;
  logic             w_accept;
  logic             w_drop;

  always_comb begin
    w_hit = '0;
    for (int n = 0; n < LANES; n++) begin
      w_hit[n] = (sel == MUX_WIDTH_FIVE'(n));
    end
  end

  // Illegal selects are always accepted so they can be dropped.
  assign w_legal  = |w_hit;
  assign w_ready  = !w_legal || |(w_hit & (~r_full | out_ready));
  assign w_accept = in_valid && w_ready;
  assign w_load   = w_hit & {LANES{w_accept}};
  assign w_drop   = w_accept && !w_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= '0;
      for (int n = 0; n < LANES; n++) begin
        r_data[n] <= '0;
      end
    end else begin
      r_full <= w_load | (r_full & ~out_ready);
      for (int n = 0; n < LANES; n++) begin
        if (w_load[n]) begin
          r_data[n] <= d;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_err <= w_drop;
      if (w_drop && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign q[g*RV_BIT_NUM_FIVE +: RV_BIT_NUM_FIVE] = r_data[g];
  end

  assign in_ready   = w_ready;
  assign out_valid  = r_full;
  assign err_sel    = r_err;
  assign drop_count = r_cnt;

endmodule

// File: tb/tb_one_to_five_demux.sv
// Scoreboard bench for one_to_five_demux: per-lane expected-word queues
// filled on accept and drained when the lane hands its word to the consumer.
module tb_one_to_five_demux;

  localparam int W  = 32;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     sel;
  logic [W-1:0]   d;
  logic [4:0]     out_valid;
  logic [4:0]     out_ready;
  logic [W*5-1:0] q;
  logic           err_sel;
  logic [CW-1:0]  drop_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb [5][$];
  logic [W-1:0] exp_w;
  logic [W-1:0] act_w;

  one_to_five_demux #(
    .RV_BIT_NUM_FIVE(W),
    .MUX_WIDTH_FIVE(3),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sel(sel),
    .d(d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q(q),
    .err_sel(err_sel),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    sel = 3'd0;
    d = '0;
    out_ready = 5'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 5'b0 || q !== '0) begin
      errors++;
      $display("FAIL reset_lanes: out_valid=%b q=%h required 0", out_valid, q);
    end
    checks++;
    if (err_sel !== 1'b0 || drop_count !== '0) begin
      errors++;
      $display("FAIL reset_err: err_sel=%b drop_count=%0d required 0/0",
               err_sel, drop_count);
    end
    step();
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    sel = 3'd2;
    d = 32'hDEADBEEF;
    out_ready = 5'b0;
    sb[2].push_back(d);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_empty: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 5'b00100) begin
      errors++;
      $display("FAIL single_valid: out_valid=%b required 00100", out_valid);
    end
    exp_w = sb[2][0];
    act_w = q[2*W +: W];
    checks++;
    if (act_w !== exp_w) begin
      errors++;
      $display("FAIL single_data: lane2=%h required %h", act_w, exp_w);
    end
    checks++;
    if (q[W*2-1:0] !== '0 || q[W*5-1:W*3] !== '0) begin
      errors++;
      $display("FAIL single_other_lanes: q=%h required others 0", q);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_full: in_ready=%b required 0", in_ready);
    end
    step();
  endtask

  task automatic test_replace();
    out_ready = 5'b00100;
    in_valid = 1'b1;
    sel = 3'd2;
    d = 32'h12345678;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL replace_ready: in_ready=%b required 1", in_ready);
    end
    exp_w = sb[2].pop_front();
    act_w = q[2*W +: W];
    checks++;
    if (out_valid[2] !== 1'b1 || act_w !== exp_w) begin
      errors++;
      $display("FAIL replace_drain: valid=%b lane2=%h required 1/%h",
               out_valid[2], act_w, exp_w);
    end
    sb[2].push_back(d);
    step();
    in_valid = 1'b0;
    out_ready = 5'b0;
    @(negedge clk);
    exp_w = sb[2][0];
    act_w = q[2*W +: W];
    checks++;
    if (out_valid !== 5'b00100 || act_w !== exp_w) begin
      errors++;
      $display("FAIL replace_data: out_valid=%b lane2=%h required 00100/%h",
               out_valid, act_w, exp_w);
    end
    step();
  endtask

  task automatic test_other_lane();
    in_valid = 1'b1;
    sel = 3'd4;
    d = 32'hA5A5A5A5;
    sb[4].push_back(d);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL other_ready: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 5'b10100) begin
      errors++;
      $display("FAIL other_valid: out_valid=%b required 10100", out_valid);
    end
    exp_w = sb[2][0];
    act_w = q[2*W +: W];
    checks++;
    if (act_w !== exp_w) begin
      errors++;
      $display("FAIL other_lane2_held: lane2=%h required %h", act_w, exp_w);
    end
    out_ready = 5'b10100;
    exp_w = sb[4].pop_front();
    act_w = q[4*W +: W];
    checks++;
    if (act_w !== exp_w) begin
      errors++;
      $display("FAIL other_lane4: lane4=%h required %h", act_w, exp_w);
    end
    void'(sb[2].pop_front());
    step();
    out_ready = 5'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 5'b0) begin
      errors++;
      $display("FAIL other_drained: out_valid=%b required 0", out_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        in_valid = 1'b1;
        sel = 3'(i);
        d = $urandom();
        sb[i].push_back(d);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready[%0d]: in_ready=%b required 1", i, in_ready);
      end
      if (i > 0) begin
        exp_w = sb[i-1].pop_front();
        act_w = q[(i-1)*W +: W];
        checks++;
        if (out_valid !== (5'b1 << (i-1)) || act_w !== exp_w) begin
          errors++;
          $display("FAIL stream_lane%0d: out_valid=%b data=%h required %b/%h",
                   i-1, out_valid, act_w, 5'b1 << (i-1), exp_w);
        end
      end else begin
        checks++;
        if (out_valid !== 5'b0) begin
          errors++;
          $display("FAIL stream_idle: out_valid=%b required 0", out_valid);
        end
      end
      step();
    end
    out_ready = 5'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 5'b0) begin
      errors++;
      $display("FAIL stream_end: out_valid=%b required 0", out_valid);
    end
    step();
  endtask

  task automatic test_illegal();
    int m_cnt;
    m_cnt = 0;
    in_valid = 1'b1;
    sel = 3'd6;
    out_ready = 5'b0;
    for (int k = 0; k < 300; k++) begin
      d = $urandom();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 5'b0) begin
        errors++;
        $display("FAIL illegal_ready[%0d]: in_ready=%b out_valid=%b required 1/0",
                 k, in_ready, out_valid);
      end
      checks++;
      if (err_sel !== (k > 0) || drop_count !== CW'(m_cnt)) begin
        errors++;
        $display("FAIL illegal_err[%0d]: err_sel=%b cnt=%0d required %b/%0d",
                 k, err_sel, drop_count, k > 0, m_cnt);
      end
      if (m_cnt < 255) m_cnt++;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err_sel !== 1'b1 || drop_count !== 8'd255) begin
      errors++;
      $display("FAIL illegal_sat: err_sel=%b cnt=%0d required 1/255",
               err_sel, drop_count);
    end
    step();
    @(negedge clk);
    checks++;
    if (err_sel !== 1'b0 || drop_count !== 8'd255) begin
      errors++;
      $display("FAIL illegal_idle: err_sel=%b cnt=%0d required 0/255",
               err_sel, drop_count);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 5'b0;
    in_valid = 1'b1;
    sel = 3'd1;
    d = 32'h11111111;
    sb[1].push_back(d);
    step();
    sel = 3'd3;
    d = 32'h33333333;
    sb[3].push_back(d);
    step();
    sel = 3'd0;
    d = 32'h0BADF00D;
    @(negedge clk);
    checks++;
    if (out_valid !== 5'b01010) begin
      errors++;
      $display("FAIL mid_pre: out_valid=%b required 01010", out_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 5'b0 || q !== '0) begin
      errors++;
      $display("FAIL mid_async_lanes: out_valid=%b q=%h required 0",
               out_valid, q);
    end
    checks++;
    if (drop_count !== '0 || err_sel !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_cnt: cnt=%0d err=%b required 0/0",
               drop_count, err_sel);
    end
    for (int n = 0; n < 5; n++) sb[n].delete();
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    sel = 3'd0;
    d = 32'hCAFEF00D;
    sb[0].push_back(d);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    exp_w = sb[0].pop_front();
    act_w = q[W-1:0];
    checks++;
    if (out_valid !== 5'b00001 || act_w !== exp_w) begin
      errors++;
      $display("FAIL mid_recover: out_valid=%b lane0=%h required 00001/%h",
               out_valid, act_w, exp_w);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_replace();
    test_other_lane();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
